vga_timing_ctrl: RTL and testbench
==================================

# vga_timing_ctrl

VGA timing and output stage for the 640x480@60 Hz, 25 MHz pixel path. Generates horizontal and vertical counters, sync pulses and a one-cycle-early pixel request with coordinates. It feeds `pix_x`/`pix_y` to the pixel-colour stage and the request to the SDRAM read FIFO. It gates the returned 16-bit RGB565 `pix_data` onto the display pins.

## Interface
Parameters:
- `H_SYNC`, 96, hsync width (clocks)
- `H_BACK`, 40, horizontal back porch
- `H_LEFT`, 8, left border
- `H_VALID`, 640, active pixels per line
- `H_RIGHT`, 8, right border
- `H_FRONT`, 8, front porch; `H_TOTAL` = sum = 800
- `V_SYNC`, 2, vsync width (lines)
- `V_BACK`, 25, vertical back porch
- `V_TOP`, 8, top border
- `V_VALID`, 480, active lines
- `V_BOTTOM`, 8, bottom border
- `V_FRONT`, 2, front porch; `V_TOTAL` = 525
- `SYNC_POL`, 1'b1, level of hsync/vsync during the sync pulse

Ports:
- `vga_clk` in 1: 25 MHz pixel clock; sole clock
- `sys_rst_n` in 1: asynchronous, active-low reset
- `pix_data` in 16: RGB565 from the colour stage, valid one clock after its `pix_x`/`pix_y`
- `pix_x` out 12: request column 0..639; 12'hFFF outside the request window
- `pix_y` out 12: request row 0..479; 12'hFFF outside the request window
- `pix_data_req` out 1: pixel request, one clock ahead of `rgb_valid`
- `rgb_valid` out 1: active display region
- `frame_start` out 1: one-clock pulse at the start of each frame
- `hsync` out 1: horizontal sync
- `vsync` out 1: vertical sync
- `rgb` out 16: `pix_data` when `rgb_valid`, else 16'h0000

## Operation
- **`cnt_h` (12 b):** counts 0..H_TOTAL-1, then wraps to 0.
- **`cnt_v` (12 b):** increments only on clocks where `cnt_h == H_TOTAL-1`; wraps to 0 after V_TOTAL-1. Both wrap together at (799, 524) -> (0, 0).
- **`hsync`:** equals `SYNC_POL` while `cnt_h < H_SYNC`, else `~SYNC_POL`.
- **`vsync`:** same rule using `cnt_v` and `V_SYNC`.
- **Active start offsets:** HS = H_SYNC+H_BACK+H_LEFT = 144; VS = V_SYNC+V_BACK+V_TOP = 35.
- **`rgb_valid`:** high when `cnt_h` in [144, 783] and `cnt_v` in [35, 514].
- **`pix_data_req`:** high when `cnt_h` in [143, 782] and `cnt_v` in [35, 514].
- **Coordinates:** while `pix_data_req` is high, `pix_x = cnt_h - 143` and `pix_y = cnt_v - 35`; otherwise both are 12'hFFF.
- **`rgb`:** combinational `rgb_valid ? pix_data : 0`. Border and porch regions output black.
- **`frame_start`:** registered; high for exactly the clock in which the counters read (0, 0) after a wrap. It does not fire for the first frame after reset release.
- **Arithmetic:** all unsigned, 12 bit, no saturation. Parameter sums must be < 4096.

## Timing
- **Reset state:** `cnt_h = cnt_v = 0`, so `hsync = vsync = SYNC_POL`. Also `rgb_valid = 0`, `pix_data_req = 0`, `pix_x = pix_y = 12'hFFF`, `rgb = 0`, `frame_start = 0`.
- **Reset mid-frame:** counters return to 0 asynchronously. The frame restarts from the sync region and no partial `frame_start` is issued.
- **Request-to-pixel latency:** exactly 1 clock. The pixel requested at cycle t is displayed at t+1 with `rgb_valid` high.
- **Request count:** exactly 640 request clocks per active line and 480 request lines per frame.
- **Periods:** line = 800 clocks; frame = 420 000 clocks.
- **Decode style:** all outputs except `frame_start` are combinational decodes of registered counters. Output pins are re-registered at the top level.

## Structure
- **Shared package `vga_timing_pkg`:** holds the 640x480 timing constants, derived totals and active offsets (HS = 144, VS = 35), and the RGB565 black constant. The colour stage and the SDRAM read logic reuse these.
- **Sub-modules:** none. The two counters and the decodes form one module of roughly 150 lines.

## Test plan
- **Reset release:** release reset -> `hsync`/`vsync` = 1 for 96 clocks / 2 lines. First `pix_data_req` at `cnt_h` 143 of line 35, with `pix_x = 0`, `pix_y = 0`.
- **Line timing:** run one line -> exactly 640 `pix_data_req` clocks and 640 `rgb_valid` clocks. `rgb_valid` rises exactly 1 clock after `pix_data_req`. `pix_x` runs 0..639 then returns to 12'hFFF.
- **Pass-through and gating:** drive `pix_data = {4'h0, pix_x}` delayed by 1 clock -> `rgb` equals the expected x for every active pixel and is 16'h0000 at `cnt_h` 784..799 and on line 515.
- **Frame timing:** run 2 frames -> `frame_start` pulses once, at cycle 420 000 after release. Next pulse follows 420 000 clocks later. `vsync` period is 420 000 clocks.
- **Reset mid-operation:** assert reset at line 200, pixel 300 -> all outputs take their reset values immediately. After release, the timing matches the reset-release scenario.
- **Sync polarity:** set `SYNC_POL = 0` -> `hsync` low for 96 clocks per line and `vsync` low for 1600 clocks per frame.

Source files
------------

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared 640x480@60 Hz timing constants, derived totals, active
//               window offsets and the RGB565 black level. The VGA timing
//               controller, colour stage and SDRAM read path all use these.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  // Horizontal timing in pixel clocks
  localparam int unsigned c_h_sync  = 96;
  localparam int unsigned c_h_back  = 40;
  localparam int unsigned c_h_left  = 8;
  localparam int unsigned c_h_valid = 640;
  localparam int unsigned c_h_right = 8;
  localparam int unsigned c_h_front = 8;
  localparam int unsigned c_h_total = c_h_sync + c_h_back + c_h_left
                                    + c_h_valid + c_h_right + c_h_front;   // 800

  // Vertical timing in lines
  localparam int unsigned c_v_sync   = 2;
  localparam int unsigned c_v_back   = 25;
  localparam int unsigned c_v_top    = 8;
  localparam int unsigned c_v_valid  = 480;
  localparam int unsigned c_v_bottom = 8;
  localparam int unsigned c_v_front  = 2;
  localparam int unsigned c_v_total  = c_v_sync + c_v_back + c_v_top
                                     + c_v_valid + c_v_bottom + c_v_front; // 525

  // First active column / row
  localparam int unsigned c_hs = c_h_sync + c_h_back + c_h_left;           // 144
  localparam int unsigned c_vs = c_v_sync + c_v_back + c_v_top;            // 35

  localparam logic [15:0] c_rgb_black  = 16'h0000;
  localparam logic [11:0] c_coord_none = 12'hFFF;

  // Inclusive range test on a 12-bit counter
  function automatic logic in_window(input logic [11:0] val,
                                     input logic [11:0] lo,
                                     input logic [11:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_ctrl
// Description : VGA timing generator and output stage. Free-running 12-bit
//               horizontal/vertical counters drive sync pulses, an active
//               display flag, a pixel request one clock ahead of it with the
//               requested coordinates, and a one-clock frame start pulse.
//               Returned RGB565 data is gated to black outside the active area.
// Ports       :
//   vga_clk      in   pixel clock (sole clock)
//   sys_rst_n    in   asynchronous active-low reset
//   pix_data     in   RGB565 for the coordinates requested one clock earlier
//   pix_x/pix_y  out  requested column/row, 12'hFFF outside the request window
//   pix_data_req out  pixel request, leads rgb_valid by one clock
//   rgb_valid    out  active display region
//   frame_start  out  one-clock pulse when counters wrap to (0,0)
//   hsync/vsync  out  sync pulses, level SYNC_POL during the pulse
//   rgb          out  pix_data when rgb_valid, else black
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_SYNC   = c_h_sync,
  parameter int unsigned H_BACK   = c_h_back,
  parameter int unsigned H_LEFT   = c_h_left,
  parameter int unsigned H_VALID  = c_h_valid,
  parameter int unsigned H_RIGHT  = c_h_right,
  parameter int unsigned H_FRONT  = c_h_front,
  parameter int unsigned V_SYNC   = c_v_sync,
  parameter int unsigned V_BACK   = c_v_back,
  parameter int unsigned V_TOP    = c_v_top,
  parameter int unsigned V_VALID  = c_v_valid,
  parameter int unsigned V_BOTTOM = c_v_bottom,
  parameter int unsigned V_FRONT  = c_v_front,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pix_data,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        pix_data_req,
  output logic        rgb_valid,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb
);

  // Last count of each counter
  localparam logic [11:0] c_h_last = 12'(H_SYNC + H_BACK + H_LEFT + H_VALID
                                         + H_RIGHT + H_FRONT - 1);
  localparam logic [11:0] c_v_last = 12'(V_SYNC + V_BACK + V_TOP + V_VALID
                                         + V_BOTTOM + V_FRONT - 1);
  localparam logic [11:0] c_h_sync_end = 12'(H_SYNC);
  localparam logic [11:0] c_v_sync_end = 12'(V_SYNC);

  // Active display window (inclusive bounds)
  localparam logic [11:0] c_act_h_lo = 12'(H_SYNC + H_BACK + H_LEFT);
  localparam logic [11:0] c_act_h_hi = 12'(H_SYNC + H_BACK + H_LEFT + H_VALID - 1);
  localparam logic [11:0] c_act_v_lo = 12'(V_SYNC + V_BACK + V_TOP);
  localparam logic [11:0] c_act_v_hi = 12'(V_SYNC + V_BACK + V_TOP + V_VALID - 1);

  // Request window is the active window shifted one clock earlier in x only;
  // the row range is identical because a line never straddles the shift.
  localparam logic [11:0] c_req_h_lo = c_act_h_lo - 12'd1;
  localparam logic [11:0] c_req_h_hi = c_act_h_hi - 12'd1;

  logic [11:0] cnt_h_q, cnt_h_d;
  logic [11:0] cnt_v_q, cnt_v_d;
  logic        frame_start_q, frame_start_d;

  logic        w_h_end;
  logic        w_v_end;
  logic        w_v_act;

  always_comb begin
    w_h_end       = (cnt_h_q == c_h_last);
    w_v_end       = (cnt_v_q == c_v_last);
    cnt_h_d       = w_h_end ? 12'd0 : cnt_h_q + 12'd1;
    cnt_v_d       = cnt_v_q;
    if (w_h_end) begin
      cnt_v_d = w_v_end ? 12'd0 : cnt_v_q + 12'd1;
    end
    // Registered so it lines up with the clock in which the counters read
    // (0,0) after a wrap; reset clears it, so no pulse on the first frame.
    frame_start_d = w_h_end && w_v_end;
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h_q       <= 12'd0;
      cnt_v_q       <= 12'd0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_h_q       <= cnt_h_d;
      cnt_v_q       <= cnt_v_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Output decodes straight from the counter registers
  assign hsync        = (cnt_h_q < c_h_sync_end) ? SYNC_POL : ~SYNC_POL;
  assign vsync        = (cnt_v_q < c_v_sync_end) ? SYNC_POL : ~SYNC_POL;
  assign w_v_act      = in_window(cnt_v_q, c_act_v_lo, c_act_v_hi);
  assign rgb_valid    = in_window(cnt_h_q, c_act_h_lo, c_act_h_hi) && w_v_act;
  assign pix_data_req = in_window(cnt_h_q, c_req_h_lo, c_req_h_hi) && w_v_act;
  assign pix_x        = pix_data_req ? (cnt_h_q - c_req_h_lo) : c_coord_none;
  assign pix_y        = pix_data_req ? (cnt_v_q - c_act_v_lo) : c_coord_none;
  assign rgb          = rgb_valid ? pix_data : c_rgb_black;
  assign frame_start  = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_ctrl
// Description : Scoreboard testbench for vga_timing_ctrl using a reduced
//               timing (24 x 14) so several frames fit in a short run. A
//               second instance uses inverted sync polarity.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_ctrl;

  localparam int HSY = 4, HBK = 3, HLF = 2, HVA = 10, HRT = 2, HFR = 3;
  localparam int VSY = 2, VBK = 2, VTP = 1, VVA = 6,  VBT = 1, VFR = 2;
  localparam int HT  = HSY + HBK + HLF + HVA + HRT + HFR;   // 24
  localparam int VT  = VSY + VBK + VTP + VVA + VBT + VFR;   // 14
  localparam int FT  = HT * VT;                             // 336
  localparam int HS  = HSY + HBK + HLF;                     // 9
  localparam int VS  = VSY + VBK + VTP;                     // 5

  localparam int RST_CYC  = 4;
  localparam int RST_AT   = RST_CYC + 2 * FT + 8 * HT + 11; // frame 2, line 8, pixel 11
  localparam int RST_LEN  = 3;
  localparam int TOTAL    = RST_AT + RST_LEN + 2 * FT + 20;

  logic        vga_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [15:0] pix_data  = 16'h0;

  logic [11:0] pix_x_a, pix_y_a, pix_x_b, pix_y_b;
  logic        req_a, val_a, fs_a, hs_a, vs_a;
  logic        req_b, val_b, fs_b, hs_b, vs_b;
  logic [15:0] rgb_a, rgb_b;

  always #5 vga_clk = ~vga_clk;

  vga_timing_ctrl #(
    .H_SYNC(HSY), .H_BACK(HBK), .H_LEFT(HLF), .H_VALID(HVA), .H_RIGHT(HRT), .H_FRONT(HFR),
    .V_SYNC(VSY), .V_BACK(VBK), .V_TOP(VTP), .V_VALID(VVA), .V_BOTTOM(VBT), .V_FRONT(VFR),
    .SYNC_POL(1'b1)
  ) u_dut_a (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_data(pix_data),
    .pix_x(pix_x_a), .pix_y(pix_y_a), .pix_data_req(req_a), .rgb_valid(val_a),
    .frame_start(fs_a), .hsync(hs_a), .vsync(vs_a), .rgb(rgb_a)
  );

  vga_timing_ctrl #(
    .H_SYNC(HSY), .H_BACK(HBK), .H_LEFT(HLF), .H_VALID(HVA), .H_RIGHT(HRT), .H_FRONT(HFR),
    .V_SYNC(VSY), .V_BACK(VBK), .V_TOP(VTP), .V_VALID(VVA), .V_BOTTOM(VBT), .V_FRONT(VFR),
    .SYNC_POL(1'b0)
  ) u_dut_b (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_data(pix_data),
    .pix_x(pix_x_b), .pix_y(pix_y_b), .pix_data_req(req_b), .rgb_valid(val_b),
    .frame_start(fs_b), .hsync(hs_b), .vsync(vs_b), .rgb(rgb_b)
  );

  typedef struct {
    int          t;      // clocks since reset release, -1 while in reset
    int          h;
    int          v;
    logic        hs;     // sync level for SYNC_POL = 1
    logic        vs;
    logic        req;
    logic        val;
    logic        fs;
    logic [11:0] x;
    logic [11:0] y;
    logic [15:0] rgb;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %0h, expected %0h", nm, t, act, exp);
    end
  endtask

  // Reference model: screen position from elapsed clocks, then region rules.
  function automatic exp_t model(input int t, input logic [15:0] data);
    exp_t e;
    e.t   = t;
    e.h   = (t < 0) ? 0 : t % HT;
    e.v   = (t < 0) ? 0 : (t / HT) % VT;
    e.hs  = (e.h < HSY);
    e.vs  = (e.v < VSY);
    e.val = (e.h >= HS) && (e.h < HS + HVA) && (e.v >= VS) && (e.v < VS + VVA);
    e.req = (e.h >= HS - 1) && (e.h < HS + HVA - 1) && (e.v >= VS) && (e.v < VS + VVA);
    e.x   = e.req ? 12'(e.h - (HS - 1)) : 12'hFFF;
    e.y   = e.req ? 12'(e.v - VS) : 12'hFFF;
    e.fs  = (t > 0) && (t % FT == 0);
    e.rgb = e.val ? data : 16'h0000;
    return e;
  endfunction

  // Stimulus: reset schedule and random pixel data, one expectation per clock
  initial begin
    int   t;
    logic in_rst;
    t = -1;
    for (int c = 0; c < TOTAL; c++) begin
      @(posedge vga_clk);
      #1;
      in_rst    = (c < RST_CYC) || (c >= RST_AT && c < RST_AT + RST_LEN);
      sys_rst_n = !in_rst;
      t         = in_rst ? -1 : t + 1;
      pix_data  = 16'($urandom);
      exp_q.push_back(model(t, pix_data));
    end
    @(negedge vga_clk);
    #1;
    chk("drain", -1, 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Monitor: compare both instances against each expectation, plus per-line
  // and per-frame request/valid counts from the DUT outputs.
  initial begin
    exp_t e;
    int   req_line  = 0;
    int   val_line  = 0;
    int   req_frame = 0;
    forever begin
      @(negedge vga_clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("hsync",       e.t, 32'(hs_a),    32'(e.hs));
        chk("vsync",       e.t, 32'(vs_a),    32'(e.vs));
        chk("pix_data_req",e.t, 32'(req_a),   32'(e.req));
        chk("rgb_valid",   e.t, 32'(val_a),   32'(e.val));
        chk("frame_start", e.t, 32'(fs_a),    32'(e.fs));
        chk("pix_x",       e.t, 32'(pix_x_a), 32'(e.x));
        chk("pix_y",       e.t, 32'(pix_y_a), 32'(e.y));
        chk("rgb",         e.t, 32'(rgb_a),   32'(e.rgb));
        chk("hsync_pol0",  e.t, 32'(hs_b),    32'(!e.hs));
        chk("vsync_pol0",  e.t, 32'(vs_b),    32'(!e.vs));
        chk("b_region",    e.t, {26'd0, req_b, val_b, fs_b, 3'd0},
                                {26'd0, e.req, e.val, e.fs, 3'd0});
        chk("b_coord",     e.t, {8'd0, pix_x_b, pix_y_b}, {8'd0, e.x, e.y});
        chk("b_rgb",       e.t, 32'(rgb_b),   32'(e.rgb));
        if (e.t < 0) begin
          req_line  = 0;
          val_line  = 0;
          req_frame = 0;
        end else begin
          req_line  += int'(req_a);
          val_line  += int'(val_a);
          req_frame += int'(req_a);
          if (e.h == HT - 1) begin
            if (e.v >= VS && e.v < VS + VVA) begin
              chk("req_per_line",   e.t, 32'(req_line), 32'(HVA));
              chk("valid_per_line", e.t, 32'(val_line), 32'(HVA));
            end
            req_line = 0;
            val_line = 0;
            if (e.v == VT - 1) begin
              chk("req_per_frame", e.t, 32'(req_frame), 32'(HVA * VVA));
              req_frame = 0;
            end
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
